// File: rtl/pc_sched_pkg.sv
// Shared branch codes and execution-mode encoding for the time-sliced program counter.
package pc_sched_pkg;

    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_JMP  = 3'b001;
    localparam logic [2:0] BR_JZ   = 3'b010;
    localparam logic [2:0] BR_JR   = 3'b011;
    localparam logic [2:0] BR_JNZ  = 3'b100;
    localparam logic [2:0] BR_JN   = 3'b101;
    localparam logic [2:0] BR_JLE  = 3'b110;
    localparam logic [2:0] BR_HOLD = 3'b111;

    typedef enum logic {
        MODE_OS   = 1'b0,
        MODE_USER = 1'b1
    } mode_e;

endpackage

// File: rtl/pc_rr_select.sv
// Round-robin finder: first active slot strictly after ptr_i, wrapping, ptr_i itself last.
// Purely combinational; no stall behaviour.
module pc_rr_select
    import pc_sched_pkg::*;
#(
    parameter int NUM_PROG = 4,
    parameter int PW       = $clog2(NUM_PROG + 1)
) (
    input  logic [NUM_PROG-1:0] active_mask_i,
    input  logic [PW-1:0]       ptr_i,
    output logic                found_o,
    output logic [PW-1:0]       next_slot_o
);

    logic          found_hi;
    logic          found_lo;
    logic [PW-1:0] slot_hi;
    logic [PW-1:0] slot_lo;

    // Descending scan: the last hit in each half is the lowest-numbered slot of that half.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        slot_hi  = '0;
        slot_lo  = '0;
        for (int s = NUM_PROG; s >= 1; s--) begin
            if (active_mask_i[s-1]) begin
                if (PW'(s) > ptr_i) begin
                    found_hi = 1'b1;
                    slot_hi  = PW'(s);
                end else begin
                    found_lo = 1'b1;
                    slot_lo  = PW'(s);
                end
            end
        end
        found_o     = found_hi | found_lo;
        next_slot_o = found_hi ? slot_hi : slot_lo;
    end

endmodule

// File: rtl/pc_sched.sv
// Fetch-stage program counter with round-robin time slicing of user programs under an OS slot 0.
// One-cycle update per rising edge; stop freezes execution state while program loads still land.
module pc_sched
    import pc_sched_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int NUM_PROG    = 4,
    parameter int QUANTUM     = 5,
    parameter int PROG_STRIDE = 1000,
    parameter int OS_ENTRY    = 0,
    parameter int RESET_ADDR  = 999
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stop,
    input  logic                           lpc,
    input  logic                           end_program,
    input  logic [2:0]                     desvio,
    input  logic [ADDR_W-1:0]              novo_end,
    input  logic [ADDR_W-1:0]              novo_end_r,
    input  logic                           zero,
    input  logic                           negativo,
    input  logic                           prog_load,
    input  logic [$clog2(NUM_PROG+1)-1:0]  prog_slot,
    input  logic [ADDR_W-1:0]              prog_start,
    output logic [ADDR_W-1:0]              endereco,
    output logic [ADDR_W-1:0]              spc,
    output logic [$clog2(NUM_PROG+1)-1:0]  prog_atual,
    output logic                           user_mode,
    output logic [NUM_PROG-1:0]            active_mask
);

    localparam int PW = $clog2(NUM_PROG + 1);
    localparam int CW = $clog2(QUANTUM + 1);

    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] spc_q, spc_d;
    logic [PW-1:0]     prog_atual_q, prog_atual_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    mode_e             mode_q, mode_d;
    logic [CW-1:0]     count_q, count_d;
    // Slot-indexed vectors; entry 0 (OS) is never set.
    logic [NUM_PROG:0] active_q, active_d;
    logic [NUM_PROG:0] pend_q, pend_d;
    logic [ADDR_W-1:0] saved_q [0:NUM_PROG];
    logic [ADDR_W-1:0] saved_d [0:NUM_PROG];

    logic              rr_found;
    logic [PW-1:0]     rr_slot;
    logic [ADDR_W-1:0] cur_base;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] rel_tgt;
    logic [ADDR_W-1:0] br_target;
    logic              trap;
    logic              dispatch;
    logic              load_ok;

    function automatic logic [ADDR_W-1:0] slot_base(input logic [PW-1:0] s);
        return ADDR_W'(s) * ADDR_W'(PROG_STRIDE);
    endfunction

    pc_rr_select #(
        .NUM_PROG (NUM_PROG),
        .PW       (PW)
    ) u_rr (
        .active_mask_i (active_q[NUM_PROG:1]),
        .ptr_i         (rr_ptr_q),
        .found_o       (rr_found),
        .next_slot_o   (rr_slot)
    );

    assign cur_base = (mode_q == MODE_USER) ? slot_base(prog_atual_q) : '0;
    assign incr     = endereco_q + ADDR_W'(1);
    assign rel_tgt  = novo_end + cur_base;
    assign trap     = !stop && (mode_q == MODE_USER) &&
                      ((count_q == CW'(QUANTUM)) || end_program);
    assign dispatch = !stop && (mode_q == MODE_OS) && lpc && rr_found;
    assign load_ok  = prog_load && (prog_slot != '0) && (prog_slot <= PW'(NUM_PROG));

    always_comb begin
        br_target = incr;
        case (desvio)
            BR_SEQ:  br_target = incr;
            BR_JMP:  br_target = rel_tgt;
            BR_JZ:   br_target = zero ? rel_tgt : incr;
            BR_JNZ:  br_target = zero ? incr : rel_tgt;
            BR_JN:   br_target = negativo ? rel_tgt : incr;
            BR_JLE:  br_target = (negativo | zero) ? rel_tgt : incr;
            BR_JR:   br_target = novo_end_r;
            BR_HOLD: br_target = endereco_q;
            default: br_target = incr;
        endcase
    end

    always_comb begin
        endereco_d   = endereco_q;
        spc_d        = spc_q;
        prog_atual_d = prog_atual_q;
        rr_ptr_d     = rr_ptr_q;
        mode_d       = mode_q;
        count_d      = count_q;
        active_d     = active_q;
        pend_d       = pend_q;
        saved_d      = saved_q;

        if (trap) begin
            spc_d        = incr;
            endereco_d   = ADDR_W'(OS_ENTRY);
            count_d      = '0;
            prog_atual_d = '0;
            mode_d       = MODE_OS;
            rr_ptr_d     = prog_atual_q;
            pend_d[prog_atual_q] = 1'b0;
            // A reload received while running supersedes the return context.
            if (!pend_q[prog_atual_q]) begin
                if (end_program) begin
                    active_d[prog_atual_q] = 1'b0;
                    saved_d[prog_atual_q]  = '0;
                end else begin
                    saved_d[prog_atual_q] = incr - cur_base;
                end
            end
        end else if (dispatch) begin
            endereco_d   = slot_base(rr_slot) + saved_q[rr_slot];
            prog_atual_d = rr_slot;
            mode_d       = MODE_USER;
            count_d      = '0;
        end else if (!stop) begin
            endereco_d = br_target;
            if ((mode_q == MODE_USER) && (count_q != CW'(QUANTUM))) begin
                count_d = count_q + CW'(1);
            end
        end

        if (load_ok) begin
            active_d[prog_slot] = 1'b1;
            saved_d[prog_slot]  = prog_start;
            if ((mode_q == MODE_USER) && (prog_slot == prog_atual_q) && !trap) begin
                pend_d[prog_slot] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            endereco_q   <= ADDR_W'(RESET_ADDR);
            spc_q        <= '0;
            prog_atual_q <= '0;
            rr_ptr_q     <= PW'(NUM_PROG);
            mode_q       <= MODE_OS;
            count_q      <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            for (int i = 0; i <= NUM_PROG; i++) begin
                saved_q[i] <= '0;
            end
        end else begin
            endereco_q   <= endereco_d;
            spc_q        <= spc_d;
            prog_atual_q <= prog_atual_d;
            rr_ptr_q     <= rr_ptr_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            saved_q      <= saved_d;
        end
    end

    assign endereco    = endereco_q;
    assign spc         = spc_q;
    assign prog_atual  = prog_atual_q;
    assign user_mode   = (mode_q == MODE_USER);
    assign active_mask = active_q[NUM_PROG:1];

endmodule

// File: tb/tb_pc_sched.sv
// Directed scheduler scenarios followed by random traffic, checked against a behavioural model.
module tb_pc_sched;

    localparam int AW     = 32;
    localparam int NP     = 4;
    localparam int Q      = 5;
    localparam int STRIDE = 1000;
    localparam int PW     = 3;

    logic          clock = 1'b0;
    logic          reset, stop, lpc, end_program, zero, negativo, prog_load;
    logic [2:0]    desvio;
    logic [AW-1:0] novo_end, novo_end_r, prog_start;
    logic [PW-1:0] prog_slot;
    logic [AW-1:0] endereco, spc;
    logic [PW-1:0] prog_atual;
    logic          user_mode;
    logic [NP-1:0] active_mask;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc, m_spc;
    int          m_cur, m_ptr, m_cnt;
    bit          m_user;
    bit          m_act   [1:NP];
    bit          m_pend  [1:NP];
    logic [31:0] m_saved [1:NP];

    always #5 clock = ~clock;

    pc_sched dut (
        .clock       (clock),
        .reset       (reset),
        .stop        (stop),
        .lpc         (lpc),
        .end_program (end_program),
        .desvio      (desvio),
        .novo_end    (novo_end),
        .novo_end_r  (novo_end_r),
        .zero        (zero),
        .negativo    (negativo),
        .prog_load   (prog_load),
        .prog_slot   (prog_slot),
        .prog_start  (prog_start),
        .endereco    (endereco),
        .spc         (spc),
        .prog_atual  (prog_atual),
        .user_mode   (user_mode),
        .active_mask (active_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc   = 32'd999;
        m_spc  = 32'd0;
        m_cur  = 0;
        m_ptr  = NP;
        m_cnt  = 0;
        m_user = 1'b0;
        for (int s = 1; s <= NP; s++) begin
            m_act[s]   = 1'b0;
            m_pend[s]  = 1'b0;
            m_saved[s] = 32'd0;
        end
    endtask

    // Advances the model by one edge using the inputs as they stand at that edge.
    task automatic m_step();
        logic [31:0] base, ret, tgt;
        int          pick, pre_cur, slot;
        bit          pre_user, trap_now, cond;
        if (!reset) begin
            m_reset();
            return;
        end
        pre_user = m_user;
        pre_cur  = m_cur;
        base     = m_user ? 32'(m_cur * STRIDE) : 32'd0;
        trap_now = !stop && m_user && (m_cnt == Q || end_program);
        pick = 0;
        for (int k = 1; k <= NP; k++) begin
            slot = (m_ptr + k - 1) % NP + 1;
            if (pick == 0 && m_act[slot]) pick = slot;
        end
        if (trap_now) begin
            ret   = m_pc + 32'd1;
            m_spc = ret;
            if (m_pend[m_cur]) m_pend[m_cur] = 1'b0;
            else if (end_program) begin
                m_act[m_cur]   = 1'b0;
                m_saved[m_cur] = 32'd0;
            end else m_saved[m_cur] = ret - base;
            m_ptr  = m_cur;
            m_cur  = 0;
            m_user = 1'b0;
            m_pc   = 32'd0;
            m_cnt  = 0;
        end else if (!stop && !m_user && lpc && pick != 0) begin
            m_pc   = 32'(pick * STRIDE) + m_saved[pick];
            m_cur  = pick;
            m_user = 1'b1;
            m_cnt  = 0;
        end else if (!stop) begin
            tgt = novo_end + base;
            case (desvio)
                3'b001:  cond = 1'b1;
                3'b010:  cond = zero;
                3'b100:  cond = !zero;
                3'b101:  cond = negativo;
                3'b110:  cond = negativo || zero;
                default: cond = 1'b0;
            endcase
            if (desvio == 3'b011)      m_pc = novo_end_r;
            else if (desvio == 3'b111) m_pc = m_pc;
            else if (cond)             m_pc = tgt;
            else                       m_pc = m_pc + 32'd1;
            if (m_user && m_cnt < Q) m_cnt++;
        end
        slot = int'(prog_slot);
        if (prog_load && slot >= 1 && slot <= NP) begin
            m_act[slot]   = 1'b1;
            m_saved[slot] = prog_start;
            if (pre_user && slot == pre_cur && !trap_now) m_pend[slot] = 1'b1;
        end
    endtask

    task automatic chk_all();
        logic [NP-1:0] em;
        for (int s = 1; s <= NP; s++) em[s-1] = m_act[s];
        chk("m_endereco", endereco, m_pc);
        chk("m_spc", spc, m_spc);
        chk("m_prog_atual", 32'(prog_atual), 32'(m_cur));
        chk("m_user_mode", 32'(user_mode), 32'(m_user));
        chk("m_active_mask", 32'(active_mask), 32'(em));
    endtask

    task automatic tick();
        @(posedge clock);
        m_step();
        #1;
        chk_all();
    endtask

    task automatic set_idle();
        stop = 1'b0; lpc = 1'b0; end_program = 1'b0; desvio = 3'b000;
        zero = 1'b0; negativo = 1'b0; prog_load = 1'b0; prog_slot = '0;
        prog_start = '0; novo_end = '0; novo_end_r = '0;
    endtask

    initial begin
        m_reset();
        set_idle();
        reset = 1'b0;
        tick(); tick();
        chk("rst_endereco", endereco, 32'd999);
        chk("rst_spc", spc, 32'd0);
        chk("rst_prog", 32'(prog_atual), 32'd0);
        chk("rst_user", 32'(user_mode), 32'd0);
        chk("rst_mask", 32'(active_mask), 32'd0);

        reset = 1'b1;
        tick(); chk("idle_1000", endereco, 32'd1000);
        tick(); chk("idle_1001", endereco, 32'd1001);
        lpc = 1'b1;
        tick(); chk("lpc_nomask", endereco, 32'd1002);
        chk("lpc_nomask_user", 32'(user_mode), 32'd0);
        lpc = 1'b0;

        desvio = 3'b011; novo_end_r = 32'hFFFF_FFFF;
        tick(); chk("jr_max", endereco, 32'hFFFF_FFFF);
        desvio = 3'b000;
        tick(); chk("wrap_zero", endereco, 32'd0);

        desvio = 3'b001; novo_end = 32'd4;
        prog_load = 1'b1; prog_slot = 3'd1; prog_start = 32'd0;
        tick(); chk("os_jmp", endereco, 32'd4);
        desvio = 3'b000; prog_slot = 3'd2; prog_start = 32'd10;
        tick(); chk("os_seq5", endereco, 32'd5);
        prog_load = 1'b0;
        chk("mask_12", 32'(active_mask), 32'd3);

        lpc = 1'b1;
        tick(); chk("disp1_pc", endereco, 32'd1000);
        chk("disp1_prog", 32'(prog_atual), 32'd1);
        chk("disp1_user", 32'(user_mode), 32'd1);
        lpc = 1'b0;
        repeat (5) tick();
        chk("quantum_last", endereco, 32'd1005);
        tick(); chk("trap_pc", endereco, 32'd0);
        chk("trap_spc", spc, 32'd1006);
        chk("trap_user", 32'(user_mode), 32'd0);

        lpc = 1'b1;
        tick(); chk("disp2_pc", endereco, 32'd2010);
        chk("disp2_prog", 32'(prog_atual), 32'd2);
        lpc = 1'b0; end_program = 1'b1;
        tick(); chk("end_pc", endereco, 32'd0);
        chk("end_mask", 32'(active_mask), 32'd1);
        end_program = 1'b0; lpc = 1'b1;
        tick(); chk("resume1_pc", endereco, 32'd1006);
        lpc = 1'b0;

        prog_load = 1'b1; prog_slot = 3'd3; prog_start = 32'd4;
        tick(); prog_load = 1'b0; end_program = 1'b1;
        tick(); chk("end1_mask", 32'(active_mask), 32'd4);
        end_program = 1'b0; lpc = 1'b1;
        tick(); chk("disp3_pc", endereco, 32'd3004);
        chk("disp3_prog", 32'(prog_atual), 32'd3);
        lpc = 1'b0;
        desvio = 3'b010; zero = 1'b1; novo_end = 32'd20;
        tick(); chk("jz_taken", endereco, 32'd3020);
        zero = 1'b0; desvio = 3'b011; novo_end_r = 32'd7;
        tick(); chk("jr_abs", endereco, 32'd7);
        desvio = 3'b111;
        tick(); chk("hold", endereco, 32'd7);
        desvio = 3'b000;
        tick(); chk("seq8", endereco, 32'd8);
        stop = 1'b1;
        repeat (3) tick();
        chk("stop_pc", endereco, 32'd8);
        chk("stop_user", 32'(user_mode), 32'd1);
        stop = 1'b0;
        tick(); chk("post_stop", endereco, 32'd9);
        chk("post_stop_user", 32'(user_mode), 32'd1);
        tick(); chk("trap3_pc", endereco, 32'd0);
        chk("trap3_spc", spc, 32'd10);

        prog_load = 1'b1; prog_slot = 3'd2; prog_start = 32'd3;
        tick(); prog_load = 1'b0;
        chk("mask_23", 32'(active_mask), 32'd6);
        lpc = 1'b1;
        tick(); chk("disp2b_pc", endereco, 32'd2003);
        lpc = 1'b0; reset = 1'b0;
        tick(); chk("rst_user_pc", endereco, 32'd999);
        chk("rst_user_mask", 32'(active_mask), 32'd0);
        chk("rst_user_prog", 32'(prog_atual), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 2500; i++) begin
            reset       = ($urandom_range(0, 99) != 0);
            stop        = ($urandom_range(0, 9) == 0);
            lpc         = ($urandom_range(0, 2) == 0);
            end_program = ($urandom_range(0, 19) == 0);
            desvio      = 3'($urandom_range(0, 7));
            zero        = 1'($urandom_range(0, 1));
            negativo    = 1'($urandom_range(0, 1));
            novo_end    = 32'($urandom_range(0, 1999));
            novo_end_r  = $urandom;
            prog_load   = ($urandom_range(0, 7) == 0);
            prog_slot   = 3'($urandom_range(0, 7));
            prog_start  = 32'($urandom_range(0, 999));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
